// File: rtl/bp_pkg.sv
// Shared branch-predictor constants: next-PC select encodings, counter init values, width helpers.
package bp_pkg;

    localparam logic [1:0] PC_SEL_PC4   = 2'b00;
    localparam logic [1:0] PC_SEL_PRED  = 2'b01;
    localparam logic [1:0] PC_SEL_ALU   = 2'b10;
    localparam logic [1:0] PC_SEL_EXPC4 = 2'b11;

    function automatic int ctr_weak_nt(input int cnt_w);
        return (1 << (cnt_w - 1)) - 1;
    endfunction

    function automatic int ctr_weak_t(input int cnt_w);
        return 1 << (cnt_w - 1);
    endfunction

    function automatic int tag_w(input int xlen, input int idx_w);
        return xlen - idx_w - 2;
    endfunction

    // History length is capped at 10 bits regardless of table size
    function automatic int ghr_w(input int idx_w);
        return (idx_w > 10) ? 10 : idx_w;
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Per-entry saturating direction counter; resets weakly-not-taken, set_i loads weakly-taken.
module bp_sat_counter
    import bp_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             dec_i,
    input  logic             set_i,
    output logic [CNT_W-1:0] cnt_o
);
    localparam logic [CNT_W-1:0] MAX = '1;
    localparam logic [CNT_W-1:0] WNT = CNT_W'(ctr_weak_nt(CNT_W));
    localparam logic [CNT_W-1:0] WT  = CNT_W'(ctr_weak_t(CNT_W));

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (set_i)
            cnt_d = WT;
        else if (inc_i && cnt_q != MAX)
            cnt_d = cnt_q + 1'b1;
        else if (dec_i && cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= WNT;
        else        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_predict_unit.sv
// IF-stage direct-mapped BTB predictor with EX-stage resolution, redirect and perf counters.
// Define BP_GSHARE_EN to XOR a non-speculative global history into the fetch index.
module branch_predict_unit
    import bp_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int IDX_W  = 6,
    parameter int CNT_W  = 2,
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_valid,
    input  logic [XLEN-1:0]   if_pc,
    output logic              if_pred_taken,
    output logic [XLEN-1:0]   if_pred_tgt,
    output logic [IDX_W-1:0]  if_idx,
    input  logic              ex_valid,
    input  logic [XLEN-1:0]   ex_pc,
    input  logic [IDX_W-1:0]  ex_idx,
    input  logic              ex_pred_taken,
    input  logic [XLEN-1:0]   ex_pred_tgt,
    input  logic              ex_taken,
    input  logic [XLEN-1:0]   ex_target,
    output logic [1:0]        pc_sel,
    output logic [XLEN-1:0]   redirect_pc,
    output logic              flush,
    output logic [PERF_W-1:0] perf_branches,
    output logic [PERF_W-1:0] perf_mispred
);
    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_W   = tag_w(XLEN, IDX_W);

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [XLEN-1:0]    tgt_q [ENTRIES];
    logic [CNT_W-1:0]   cnt   [ENTRIES];
    logic [PERF_W-1:0]  perf_br_q, perf_mp_q;

    logic [TAG_W-1:0] if_tag, ex_tag;
    logic             if_hit, ex_hit, mispred, alloc;
    logic             unused_pc_lsb;

`ifdef BP_GSHARE_EN
    localparam int GHR_W = ghr_w(IDX_W);
    logic [GHR_W-1:0] ghr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        ghr_q <= '0;
        else if (ex_valid) ghr_q <= (ghr_q << 1) | GHR_W'(ex_taken);
    end

    assign if_idx = if_pc[IDX_W+1:2] ^ IDX_W'(ghr_q);
`else
    assign if_idx = if_pc[IDX_W+1:2];
`endif

    assign unused_pc_lsb = ^if_pc[1:0];

    // Lookup reads registered state only, so a same-cycle update is not visible until next cycle
    assign if_tag        = if_pc[XLEN-1:IDX_W+2];
    assign if_hit        = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign if_pred_taken = if_hit && cnt[if_idx][CNT_W-1];
    assign if_pred_tgt   = tgt_q[if_idx];

    assign ex_tag  = ex_pc[XLEN-1:IDX_W+2];
    assign ex_hit  = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    assign alloc   = ex_valid && !ex_hit && ex_taken;
    assign mispred = ex_valid && ((ex_taken != ex_pred_taken) ||
                     (ex_taken && ex_pred_taken && (ex_target != ex_pred_tgt)));

    always_comb begin
        pc_sel      = PC_SEL_PC4;
        redirect_pc = '0;
        flush       = 1'b0;
        if (mispred && ex_taken) begin
            pc_sel      = PC_SEL_ALU;
            redirect_pc = ex_target;
            flush       = 1'b1;
        end else if (mispred) begin
            pc_sel      = PC_SEL_EXPC4;
            redirect_pc = ex_pc + XLEN'(4);
            flush       = 1'b1;
        end else if (if_valid && if_pred_taken) begin
            pc_sel      = PC_SEL_PRED;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
            end
        end else if (ex_valid && ex_taken) begin
            tgt_q[ex_idx] <= ex_target;
            if (!ex_hit) begin
                valid_q[ex_idx] <= 1'b1;
                tag_q[ex_idx]   <= ex_tag;
            end
        end
    end

    for (genvar e = 0; e < ENTRIES; e++) begin : g_ctr
        logic sel;
        assign sel = ex_valid && (ex_idx == IDX_W'(e));
        bp_sat_counter #(.CNT_W(CNT_W)) u_ctr (
            .clk   (clk),
            .rst_n (rst_n),
            .inc_i (sel && ex_hit && ex_taken),
            .dec_i (sel && ex_hit && !ex_taken),
            .set_i (sel && alloc),
            .cnt_o (cnt[e])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_br_q <= '0;
            perf_mp_q <= '0;
        end else begin
            if (ex_valid && perf_br_q != '1) perf_br_q <= perf_br_q + 1'b1;
            if (mispred  && perf_mp_q != '1) perf_mp_q <= perf_mp_q + 1'b1;
        end
    end

    assign perf_branches = perf_br_q;
    assign perf_mispred  = perf_mp_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed scoreboard bench: driver pushes hand-computed expectations, negedge monitor pops and compares.
module tb_branch_predict_unit;
    localparam int XLEN = 32, IDX_W = 6, CNT_W = 2, PERF_W = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              if_valid = 1'b0;
    logic [XLEN-1:0]   if_pc = '0;
    logic              if_pred_taken;
    logic [XLEN-1:0]   if_pred_tgt;
    logic [IDX_W-1:0]  if_idx;
    logic              ex_valid = 1'b0;
    logic [XLEN-1:0]   ex_pc = '0;
    logic [IDX_W-1:0]  ex_idx = '0;
    logic              ex_pred_taken = 1'b0;
    logic [XLEN-1:0]   ex_pred_tgt = '0;
    logic              ex_taken = 1'b0;
    logic [XLEN-1:0]   ex_target = '0;
    logic [1:0]        pc_sel;
    logic [XLEN-1:0]   redirect_pc;
    logic              flush;
    logic [PERF_W-1:0] perf_branches, perf_mispred;

    branch_predict_unit #(.XLEN(XLEN), .IDX_W(IDX_W), .CNT_W(CNT_W), .PERF_W(PERF_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_valid(if_valid), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
        .if_pred_tgt(if_pred_tgt), .if_idx(if_idx),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_idx(ex_idx), .ex_pred_taken(ex_pred_taken),
        .ex_pred_tgt(ex_pred_tgt), .ex_taken(ex_taken), .ex_target(ex_target),
        .pc_sel(pc_sel), .redirect_pc(redirect_pc), .flush(flush),
        .perf_branches(perf_branches), .perf_mispred(perf_mispred)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              pt;
        logic [XLEN-1:0]   tgt;
        logic [IDX_W-1:0]  idx;
        logic [1:0]        sel;
        logic [XLEN-1:0]   red;
        logic              fl;
        logic [PERF_W-1:0] pb;
        logic [PERF_W-1:0] pm;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
        if (act !== req) begin
            n_err++;
            $display("FAIL vec%0d %s: got 0x%0h want 0x%0h", n_vec, name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("pred_taken", XLEN'(if_pred_taken), XLEN'(e.pt));
            if (e.pt) chk("pred_tgt", if_pred_tgt, e.tgt);
            chk("if_idx", XLEN'(if_idx), XLEN'(e.idx));
            chk("pc_sel", XLEN'(pc_sel), XLEN'(e.sel));
            chk("redirect", redirect_pc, e.red);
            chk("flush", XLEN'(flush), XLEN'(e.fl));
            chk("perf_br", XLEN'(perf_branches), XLEN'(e.pb));
            chk("perf_mp", XLEN'(perf_mispred), XLEN'(e.pm));
            n_vec++;
        end
    end

    task automatic vec(input logic iv, input logic [XLEN-1:0] ipc,
                       input logic ev, input logic [XLEN-1:0] epc, input logic ept,
                       input logic [XLEN-1:0] eptgt, input logic et, input logic [XLEN-1:0] etgt,
                       input logic xpt, input logic [XLEN-1:0] xtgt, input logic [1:0] xsel,
                       input logic [XLEN-1:0] xred, input logic xfl, input int xpb, input int xpm);
        exp_t e;
        @(posedge clk); #1;
        if_valid = iv; if_pc = ipc;
        ex_valid = ev; ex_pc = epc; ex_idx = epc[IDX_W+1:2];
        ex_pred_taken = ept; ex_pred_tgt = eptgt; ex_taken = et; ex_target = etgt;
        e.pt = xpt; e.tgt = xtgt; e.idx = ipc[IDX_W+1:2]; e.sel = xsel;
        e.red = xred; e.fl = xfl; e.pb = PERF_W'(xpb); e.pm = PERF_W'(xpm);
        exp_q.push_back(e);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        // reset state, fetch 0x100
        vec(1, 32'h100, 0, 0, 0, 0, 0, 0,           0, 0, 2'b00, 0, 0, 0, 0);
        // taken miss at 0x100 allocates; same-cycle lookup still sees the empty entry
        vec(1, 32'h100, 1, 32'h100, 0, 0, 1, 32'h80, 0, 0, 2'b10, 32'h80, 1, 0, 0);
        vec(1, 32'h100, 0, 0, 0, 0, 0, 0,           1, 32'h80, 2'b01, 0, 0, 1, 1);
        // predicted taken, resolves not-taken
        vec(1, 32'h100, 1, 32'h100, 1, 32'h80, 0, 0, 1, 32'h80, 2'b11, 32'h104, 1, 1, 1);
        vec(1, 32'h100, 0, 0, 0, 0, 0, 0,           0, 0, 2'b00, 0, 0, 2, 2);
        // 0x200 aliases index 0 with a different tag: overwrite, then train to saturation
        vec(1, 32'h200, 1, 32'h200, 0, 0, 1, 32'h300, 0, 0, 2'b10, 32'h300, 1, 2, 2);
        vec(1, 32'h200, 1, 32'h200, 1, 32'h300, 1, 32'h300, 1, 32'h300, 2'b01, 0, 0, 3, 3);
        vec(1, 32'h200, 1, 32'h200, 1, 32'h300, 1, 32'h300, 1, 32'h300, 2'b01, 0, 0, 4, 3);
        vec(1, 32'h200, 1, 32'h200, 1, 32'h300, 1, 32'h300, 1, 32'h300, 2'b01, 0, 0, 5, 3);
        vec(1, 32'h200, 1, 32'h200, 1, 32'h300, 1, 32'h300, 1, 32'h300, 2'b01, 0, 0, 6, 3);
        vec(1, 32'h200, 1, 32'h200, 1, 32'h300, 0, 0,     1, 32'h300, 2'b11, 32'h204, 1, 7, 3);
        vec(1, 32'h200, 0, 0, 0, 0, 0, 0,               1, 32'h300, 2'b01, 0, 0, 8, 4);
        // right direction, wrong target
        vec(1, 32'h200, 1, 32'h200, 1, 32'h300, 1, 32'h400, 1, 32'h300, 2'b10, 32'h400, 1, 8, 4);
        vec(1, 32'h200, 0, 0, 0, 0, 0, 0,               1, 32'h400, 2'b01, 0, 0, 9, 5);
        // not-taken miss does not allocate; drives perf_branches into saturation
        for (int k = 0; k < 7; k++)
            vec(1, 32'h104, 1, 32'h104, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0,
                (9 + k > 15) ? 15 : 9 + k, 5);
        vec(1, 32'h104, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 15, 5);
        // predicting state before reset
        vec(1, 32'h200, 0, 0, 0, 0, 0, 0, 1, 32'h400, 2'b01, 0, 0, 15, 5);
        // asynchronous reset mid-stream
        @(posedge clk); #1;
        rst_n = 1'b0;
        begin
            exp_t e;
            if_valid = 1; if_pc = 32'h200; ex_valid = 0;
            e.pt = 0; e.tgt = 0; e.idx = 0; e.sel = 2'b00; e.red = 0; e.fl = 0; e.pb = 0; e.pm = 0;
            exp_q.push_back(e);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        vec(1, 32'h200, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        @(posedge clk); #1;
        if_valid = 0; ex_valid = 0;
        for (int w = 0; w < 20 && exp_q.size() > 0; w++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
